// File: rtl/keypad_if.sv
// Keypad scanner bus: matrix lines plus the character output to the LCD stage.
// master = scanner side, slave = keypad matrix / consumer side.
interface keypad_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [5:0] key_code;
  logic       key_valid;
  logic [2:0] key_cnt;
  logic       busy;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_cnt,
    output busy
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_cnt,
    input  busy
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with tick-based debounce.
// Emits one 6-bit code plus a wrapping press count per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV   = 50_000,
  parameter int DEBOUNCE_N = 20
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);
  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_N + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_N  = SW'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    SCAN, DEBOUNCE, HOLD, RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    r1_q, rs_q;
  logic [TW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    coln_q;
  logic [SW-1:0] stb_q, stb_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    row_q, row_d;
  logic [5:0]    code_q, code_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          busy_q;

  logic          tick;
  logic [3:0]    low;
  logic          idle, one_low, same;
  logic [1:0]    low_idx;
  logic [SW-1:0] stb_inc;

  assign tick    = (div_q == TICK_LAST);
  assign div_d   = tick ? '0 : div_q + TW'(1);
  assign low     = ~rs_q;
  assign idle    = (rs_q == 4'b1111);
  assign one_low = (low != 4'b0) &&
                   ((low & (low - 4'd1)) == 4'b0);
  assign same    = (rs_q == pat_q);
  assign stb_inc = (stb_q == STABLE_N) ? stb_q
                                       : stb_q + SW'(1);

  always_comb begin
    low_idx = 2'd0;
    unique case (low)
      4'b0001: low_idx = 2'd0;
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low) state_d = DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!same) state_d = SCAN;
          else if (stb_inc == STABLE_N) state_d = HOLD;
        end
        HOLD: begin
          if (idle) state_d = RELEASE;
        end
        RELEASE: begin
          if (!idle) state_d = HOLD;
          else if (stb_inc == STABLE_N) state_d = SCAN;
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Column stays frozen from detection until the release is debounced.
  always_comb begin
    col_d   = col_q;
    stb_d   = stb_q;
    pat_d   = pat_q;
    row_d   = row_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low) begin
            pat_d = rs_q;
            row_d = low_idx;
            stb_d = SW'(1);
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!same) begin
            stb_d = '0;
            col_d = col_q + 2'd1;
          end else begin
            stb_d = stb_inc;
            if (stb_inc == STABLE_N) begin
              code_d  = {2'b00, row_q, col_q};
              cnt_d   = cnt_q + 3'd1;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (idle) stb_d = SW'(1);
        end
        RELEASE: begin
          if (!idle) begin
            stb_d = '0;
          end else begin
            stb_d = stb_inc;
            if (stb_inc == STABLE_N) col_d = col_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q    <= 4'b1111;
      rs_q    <= 4'b1111;
      div_q   <= '0;
      col_q   <= 2'd0;
      coln_q  <= 4'b1110;
      stb_q   <= '0;
      pat_q   <= 4'b1111;
      row_q   <= 2'd0;
      code_q  <= 6'd0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      r1_q    <= kp.row_n;
      rs_q    <= r1_q;
      div_q   <= div_d;
      col_q   <= col_d;
      coln_q  <= ~(4'b0001 << col_d);
      stb_q   <= stb_d;
      pat_q   <= pat_d;
      row_q   <= row_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != SCAN);
    end
  end

  assign kp.col_n     = coln_q;
  assign kp.key_code  = code_q;
  assign kp.key_cnt   = cnt_q;
  assign kp.key_valid = valid_q;
  assign kp.busy      = busy_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a pulse scoreboard.
// Expected {cnt,code} pushed at press time, compared against observed pulses.
module tb_keypad_scanner;
  logic        clk;
  logic        rst_n;
  logic [15:0] keys;
  int          errors;
  int          checks;
  logic [2:0]  exp_cnt;
  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  int          dbl_valid;
  logic        prev_v;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_DIV  (4),
    .DEBOUNCE_N(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    kp.row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) obs_q.push_back({kp.key_cnt, kp.key_code});
    if (kp.key_valid === 1'b1 && prev_v === 1'b1) dbl_valid++;
    prev_v = kp.key_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic v, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (kp.busy === v) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    keys  = '0;
    tick_n(3);
    checks++;
    if (kp.col_n !== 4'b1110) begin
      errors++; $display("FAIL rst_col_n: got %b expected 1110", kp.col_n);
    end
    checks++;
    if (kp.key_code !== 6'd0) begin
      errors++; $display("FAIL rst_key_code: got %0d expected 0", kp.key_code);
    end
    checks++;
    if (kp.key_cnt !== 3'd0) begin
      errors++; $display("FAIL rst_key_cnt: got %0d expected 0", kp.key_cnt);
    end
    checks++;
    if (kp.key_valid !== 1'b0 || kp.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid_busy: got %b%b expected 00", kp.key_valid, kp.busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan;
    logic [3:0] ec;
    int bad;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (kp.col_n !== ec) begin
        errors++;
        $display("FAIL idle_col_n[%0d]: got %b expected %b", k, kp.col_n, ec);
      end
      if (kp.key_valid !== 1'b0 || kp.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_quiet: %0d active cycles expected 0", bad);
    end
    obs_q.delete();
  endtask

  task automatic test_clean;
    bit ok;
    logic [8:0] e, o;
    keys[9] = 1'b1;
    exp_cnt++;
    exp_q.push_back({exp_cnt, 6'd9});
    wait_busy(1'b1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_detect: busy=0 expected 1"); end
    tick_n(40);
    checks++;
    if (kp.busy !== 1'b1) begin
      errors++; $display("FAIL clean_busy_hold: got %b expected 1", kp.busy);
    end
    keys = '0;
    tick_n(2);
    checks++;
    if (kp.busy !== 1'b1) begin
      errors++; $display("FAIL clean_busy_release: got %b expected 1", kp.busy);
    end
    wait_busy(1'b0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_idle: busy=1 expected 0"); end
    tick_n(8);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL clean_count: pulses=%0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clean_pulse: cnt/code=%0d/%0d expected %0d/%0d",
                 o[8:6], o[5:0], e[8:6], e[5:0]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce;
    bit ok, saw;
    logic [8:0] e, o;
    saw = 1'b0;
    for (int i = 0; i < 40 && kp.col_n === 4'b0111; i++) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (kp.col_n === 4'b0111) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_col3: col3 never driven"); end
    for (int p = 0; p < 4; p++) begin
      keys[3] = (p % 2 == 0);
      repeat (4) begin
        @(negedge clk);
        if (kp.busy === 1'b1) saw = 1'b1;
      end
    end
    checks++;
    if (!saw) begin errors++; $display("FAIL bounce_detect: busy=0 expected 1"); end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL bounce_abort: pulses=%0d expected 0", obs_q.size());
    end
    obs_q.delete();
    keys[3] = 1'b1;
    exp_cnt++;
    exp_q.push_back({exp_cnt, 6'd3});
    wait_busy(1'b1, 40, ok);
    tick_n(30);
    keys = '0;
    wait_busy(1'b0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_idle: busy=1 expected 0"); end
    tick_n(8);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bounce_count: pulses=%0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_pulse: cnt/code=%0d/%0d expected %0d/%0d",
                 o[8:6], o[5:0], e[8:6], e[5:0]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_hold_bounce;
    bit ok;
    int drops;
    logic [8:0] e, o;
    drops = 0;
    keys[4] = 1'b1;
    exp_cnt++;
    exp_q.push_back({exp_cnt, 6'd4});
    wait_busy(1'b1, 40, ok);
    tick_n(40);
    for (int b = 0; b < 3; b++) begin
      keys[4] = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (kp.busy !== 1'b1) drops++;
      end
      keys[4] = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (kp.busy !== 1'b1) drops++;
      end
    end
    tick_n(100);
    checks++;
    if (drops != 0) begin
      errors++; $display("FAIL hold_busy: %0d idle cycles expected 0", drops);
    end
    keys = '0;
    wait_busy(1'b0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_idle: busy=1 expected 0"); end
    tick_n(8);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL hold_count: pulses=%0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hold_pulse: cnt/code=%0d/%0d expected %0d/%0d",
                 o[8:6], o[5:0], e[8:6], e[5:0]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_ghost;
    int hi;
    logic [3:0] seen;
    hi = 0;
    seen = '0;
    keys[2]  = 1'b1;
    keys[14] = 1'b1;
    repeat (64) begin
      @(negedge clk);
      if (kp.busy !== 1'b0) hi++;
      for (int c = 0; c < 4; c++)
        if (kp.col_n === ~(4'b0001 << c)) seen[c] = 1'b1;
    end
    keys = '0;
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL ghost_busy: %0d busy cycles expected 0", hi);
    end
    checks++;
    if (seen !== 4'hf) begin
      errors++; $display("FAIL ghost_scan: columns seen %b expected 1111", seen);
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL ghost_pulse: pulses=%0d expected 0", obs_q.size());
    end
    obs_q.delete();
    tick_n(8);
  endtask

  task automatic test_wrap_reset;
    bit ok;
    logic [8:0] e, o;
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    exp_cnt = 3'd0;
    obs_q.delete(); exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      keys[15] = 1'b1;
      exp_cnt++;
      exp_q.push_back({exp_cnt, 6'd15});
      wait_busy(1'b1, 40, ok);
      tick_n(30);
      keys = '0;
      wait_busy(1'b0, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_idle[%0d]: busy=1 expected 0", n); end
      tick_n(4);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count: pulses=%0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_pulse: cnt/code=%0d/%0d expected %0d/%0d",
                 o[8:6], o[5:0], e[8:6], e[5:0]);
      end
    end
    obs_q.delete(); exp_q.delete();
    keys[15] = 1'b1;
    wait_busy(1'b1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_9th_detect: busy=0 expected 1"); end
    tick_n(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (kp.col_n !== 4'b1110 || kp.busy !== 1'b0 || kp.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: col_n/busy/valid=%b/%b/%b expected 1110/0/0",
               kp.col_n, kp.busy, kp.key_valid);
    end
    checks++;
    if (kp.key_code !== 6'd0 || kp.key_cnt !== 3'd0) begin
      errors++;
      $display("FAIL midrst_data: code/cnt=%0d/%0d expected 0/0", kp.key_code, kp.key_cnt);
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL midrst_pulse: pulses=%0d expected 0", obs_q.size());
    end
    obs_q.delete();
    tick_n(3);
    rst_n = 1'b1;
    exp_cnt = 3'd1;
    exp_q.push_back({exp_cnt, 6'd15});
    wait_busy(1'b1, 40, ok);
    tick_n(30);
    keys = '0;
    wait_busy(1'b0, 40, ok);
    tick_n(8);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL redetect_count: pulses=%0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL redetect_pulse: cnt/code=%0d/%0d expected %0d/%0d",
                 o[8:6], o[5:0], e[8:6], e[5:0]);
      end
    end
    checks++;
    if (dbl_valid != 0) begin
      errors++; $display("FAIL valid_width: %0d back-to-back pulses expected 0", dbl_valid);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_cnt   = 3'd0;
    dbl_valid = 0;
    prev_v    = 1'b0;
    keys      = '0;
    rst_n     = 1'b0;
    test_reset();
    test_idle_scan();
    test_clean();
    test_bounce();
    test_hold_bounce();
    test_ghost();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
